ttlc_io_arb: RTL
================

Name: ttlc_io_arb

Overview:
- Arbiter in front of the TTLC bit-addressed I/O space (bit-wide read/write bus: 8-bit address, write strobe, 1-bit write data, combinational 1-bit read data).
- Shares the bus between two requesters:
  - the MC14500 core, which does single-bit accesses and has normal priority;
  - a debug/host port, which does 8-bit bursts over consecutive bit addresses.
- A starvation counter guarantees the debug port forward progress while the core runs continuously.

Parameters:
- AW, 8, I/O bit-address width.
- MAX_WAIT, 4, consecutive core-owned cycles tolerated while a debug burst is pending before one slot is forced to debug (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- core_req  in  1  core requests the bus this cycle
- core_we  in  1  core access is a write
- core_addr  in  AW  core bit address
- core_wdata  in  1  core write bit
- core_gnt  out  1  core owns the bus this cycle (combinational)
- core_rdata  out  1  read bit, valid while core_gnt=1 (combinational from io_data_out)
- dbg_req  in  1  start debug byte burst (sampled only when dbg_busy=0)
- dbg_we  in  1  burst is a write
- dbg_addr  in  AW  burst base bit address
- dbg_wbyte  in  8  write data; bit i goes to dbg_addr+i
- dbg_busy  out  1  burst in progress
- dbg_ack  out  1  one-cycle pulse, burst complete
- dbg_rbyte  out  8  read data; bit i sampled from dbg_addr+i
- dbg_werr  out  1  sticky write-protect error (optional feature)
- io_address  out  AW  to I/O block address
- io_mem_write  out  1  to I/O block write enable
- io_data_in  out  1  to I/O block write data
- io_data_out  in  1  from I/O block read data

Behaviour:
- Reset values: dbg_busy=0, dbg_ack=0, dbg_rbyte=0, dbg_werr=0. Internal state cleared: bit counter=0, starve counter=0, FSM=IDLE.
- Reset mid-burst aborts the burst with no ack. Any partial writes already issued stay in the I/O block.
- FSM states:
  - IDLE: dbg_req=1 latches dbg_addr, dbg_we and dbg_wbyte; clears cnt and starve; goes to BURST. dbg_busy=1 from the next cycle.
  - BURST: each cycle, the bus owner is chosen:
    - force = (starve == MAX_WAIT).
    - If core_req && !force, the core owns the bus and starve increments (saturating).
    - Otherwise a debug slot occurs.
  - Debug slot:
    - io_address = base + cnt (modulo 2^AW, wraps 255→0).
    - io_mem_write = latched we; io_data_in = wbyte[cnt].
    - rbyte[cnt] <= io_data_out. On reads, the read is performed on every slot; on writes, rbyte captures the pre-write value.
    - starve <= 0; cnt increments.
    - The slot with cnt==7 goes to DONE.
  - DONE: dbg_ack=1 and dbg_busy=0 for one cycle; dbg_rbyte holds until the next ack. dbg_req sampled in DONE is accepted (back-to-back bursts) and goes to BURST; otherwise go to IDLE.
- Core ownership in IDLE and DONE: core_gnt = core_req. io_address = core_addr, io_mem_write = core_req & core_we, io_data_in = core_wdata.
- In a forced debug slot, core_gnt=0. The core must hold its request and retry; the arbiter does not queue it.
- No owner (core_req=0, not in a debug slot): io_address = core_addr, io_mem_write=0.
- Latency:
  - Accept at cycle T, with core idle: slots at T+1..T+8, dbg_ack at T+9.
  - With core saturating: each debug bit costs MAX_WAIT+1 cycles, so ack at T+1+8*(MAX_WAIT+1).
- Address range: no filtering of out-of-range addresses; the I/O block defines their read value.
- dbg_req asserted while dbg_busy=1 is ignored (no queueing).

Optional Feature:
- Macro: TTLC_IO_ARB_WPROT_EN.
- Defined:
  - Debug write slots with address < 48 (output-pin region) have io_mem_write forced to 0. The slot still consumes a cycle and samples rbyte.
  - dbg_werr is set sticky on the first such slot and cleared when the next burst is accepted.
  - Core writes are never blocked.
- Undefined: no suppression; dbg_werr tied 0.

Decomposition:
- Shared package ttlc_pkg:
  - TTLC_AW=8;
  - region constants TTLC_OUT_BASE=0, TTLC_OUT_BITS=48, TTLC_TMP_BASE=96;
  - FSM state enum (IDLE, BURST, DONE).
- One natural sub-module: ttlc_starve_ctr. This is a saturating counter with inc/clr inputs and a force output compared against MAX_WAIT. Everything else stays in ttlc_io_arb.

Test Plan:
- Core only: core_req=1, we=1, addr=5, wdata=1 → core_gnt=1 same cycle; io_address=5, io_mem_write=1, io_data_in=1.
- Debug read, core idle: dbg_req, we=0, addr=0x80, model bits 0x80..0x87 = 0xA5 → slots addr 0x80..0x87 on cycles T+1..T+8; dbg_ack at T+9; dbg_rbyte=0xA5.
- Starvation, MAX_WAIT=4: core_req held 1, debug write 0x3C to addr 0x60 → core_gnt low exactly 1 in every 5 cycles; 8 write slots; ack at T+41; model temp bits = 0x3C.
- Wrap, back-to-back, ignored request: debug write base 0xFE → slot addresses 0xFE, 0xFF, 0x00..0x05. dbg_req held through DONE → second burst accepted at the ack cycle. dbg_req pulsed mid-burst → no effect.
- Async reset: rst_n low during slot cnt=3 → dbg_busy=0 immediately, no ack; dbg_rbyte=0; next burst runs normally.
- WPROT_EN: debug write base 46, data 0xFF → io_mem_write=0 on addrs 46 and 47, =1 on 48..53; dbg_werr=1; cleared at next accept.

Source files
------------

// File: rtl/ttlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ttlc_pkg
// Description : Shared TTLC constants: I/O bit-address width, I/O region
//               map and the debug-arbiter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ttlc_pkg;

    // I/O bit-address width
    localparam int TTLC_AW       = 8;

    // I/O region map (bit addresses)
    localparam int TTLC_OUT_BASE = 0;
    localparam int TTLC_OUT_BITS = 48;
    localparam int TTLC_TMP_BASE = 96;

    // Debug-burst FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

endpackage : ttlc_pkg
`default_nettype wire

// File: rtl/ttlc_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : ttlc_starve_ctr
// Description : Saturating count of consecutive core-owned cycles while a
//               debug burst waits; force_slot asserts once the count reaches
//               MAX_WAIT so the next bus slot goes to the debug port.
// Revision    : 1.0 - initial release
// ============================================================================
module ttlc_starve_ctr #(
    parameter int MAX_WAIT = 4          // legal range 1..15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic force_slot
);

    logic [3:0] r_cnt;

    // Count core-owned cycles; clear wins over increment; hold at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (clr) begin
            r_cnt <= 4'd0;
        end else if (inc && (r_cnt != 4'hF)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign force_slot = (r_cnt == 4'(MAX_WAIT));

endmodule : ttlc_starve_ctr
`default_nettype wire

// File: rtl/ttlc_io_arb.sv
`default_nettype none
// ============================================================================
// Module      : ttlc_io_arb
// Description : Arbiter for the TTLC bit-addressed I/O bus. The MC14500 core
//               gets single-bit accesses at normal priority; the debug port
//               runs 8-bit bursts over consecutive bit addresses and is
//               guaranteed one slot after MAX_WAIT consecutive core cycles.
//               Optional feature macro: TTLC_IO_ARB_WPROT_EN (debug writes
//               into the output-pin region are suppressed and flagged on
//               dbg_werr).
// Revision    : 1.0 - initial release
// ============================================================================
module ttlc_io_arb
    import ttlc_pkg::*;
#(
    parameter int AW       = TTLC_AW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // MC14500 core side
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic          core_wdata,
    output logic          core_gnt,
    output logic          core_rdata,
    // debug / host side
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [7:0]    dbg_wbyte,
    output logic          dbg_busy,
    output logic          dbg_ack,
    output logic [7:0]    dbg_rbyte,
    output logic          dbg_werr,
    // I/O block side
    output logic [AW-1:0] io_address,
    output logic          io_mem_write,
    output logic          io_data_in,
    input  logic          io_data_out
);

    arb_state_t    r_state;
    arb_state_t    w_next_state;

    logic [AW-1:0] r_base;
    logic          r_we;
    logic [7:0]    r_wbyte;
    logic [2:0]    r_cnt;
    logic [6:0]    r_rbuf;
    logic [7:0]    r_rbyte;

    logic          w_force;
    logic          w_accept;
    logic          w_core_own;
    logic          w_slot;
    logic          w_last;
    logic          w_prot;
    logic [AW-1:0] w_slot_addr;

    // A new burst may start from IDLE or directly from DONE (back-to-back)
    assign w_accept    = ((r_state == IDLE) || (r_state == DONE)) && dbg_req;
    // Inside a burst the core only loses the bus when the starve limit is hit
    assign w_core_own  = core_req && !((r_state == BURST) && w_force);
    assign w_slot      = (r_state == BURST) && !w_core_own;
    assign w_last      = (r_cnt == 3'd7);
    assign w_slot_addr = r_base + AW'(r_cnt);   // wraps modulo 2^AW

`ifdef TTLC_IO_ARB_WPROT_EN
    logic r_werr;

    // Output-pin region is [TTLC_OUT_BASE, TTLC_OUT_BASE+TTLC_OUT_BITS)
    assign w_prot = ((w_slot_addr - AW'(TTLC_OUT_BASE)) < AW'(TTLC_OUT_BITS));

    // Sticky protect error, cleared when the next burst is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_werr <= 1'b0;
        end else if (w_accept) begin
            r_werr <= 1'b0;
        end else if (w_slot && r_we && w_prot) begin
            r_werr <= 1'b1;
        end
    end

    assign dbg_werr = r_werr;
`else
    assign w_prot   = 1'b0;
    assign dbg_werr = 1'b0;
`endif

    ttlc_starve_ctr #(
        .MAX_WAIT   (MAX_WAIT)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        ((r_state == BURST) && w_core_own),
        .clr        (w_accept || w_slot),
        .force_slot (w_force)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = BURST;
            BURST:   if (w_slot && w_last) w_next_state = DONE;
            DONE:    w_next_state = w_accept ? BURST : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs and bus multiplexer
    always_comb begin
        dbg_busy     = (r_state == BURST);
        dbg_ack      = (r_state == DONE);
        core_gnt     = 1'b0;
        io_address   = core_addr;
        io_mem_write = 1'b0;
        io_data_in   = core_wdata;
        if (w_slot) begin
            io_address   = w_slot_addr;
            io_mem_write = r_we && !w_prot;
            io_data_in   = r_wbyte[r_cnt];
        end else if (w_core_own) begin
            core_gnt     = 1'b1;
            io_mem_write = core_we;
        end
    end

    // Burst datapath: latch request on accept, step bit counter per slot.
    // Read bits shift into r_rbuf so dbg_rbyte only changes on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base  <= '0;
            r_we    <= 1'b0;
            r_wbyte <= 8'd0;
            r_cnt   <= 3'd0;
            r_rbuf  <= 7'd0;
            r_rbyte <= 8'd0;
        end else if (w_accept) begin
            r_base  <= dbg_addr;
            r_we    <= dbg_we;
            r_wbyte <= dbg_wbyte;
            r_cnt   <= 3'd0;
        end else if (w_slot) begin
            r_cnt  <= r_cnt + 3'd1;
            r_rbuf <= {io_data_out, r_rbuf[6:1]};
            if (w_last) begin
                r_rbyte <= {io_data_out, r_rbuf};
            end
        end
    end

    assign dbg_rbyte  = r_rbyte;
    assign core_rdata = io_data_out;

endmodule : ttlc_io_arb
`default_nettype wire
